// File: rtl/fifo_uart_pkg.sv
// Shared types and line levels for the FIFO-drain UART transmitter.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// Bit-period timer: tick is high on the last clk cycle of every serial bit.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the synchronous byte FIFO and sends each as an 8N1 frame on tx.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tick;
    logic              baud_clear;

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (tick)
    );

    // Outputs decode from registered state only, so reset forces tx high without a clock.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        baud_clear = 1'b0;
        rd         = 1'b0;
        tx         = IDLE_LEVEL;
        busy       = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (en && !empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                rd      = 1'b1;
                state_d = LOAD;
            end
            LOAD: begin
                shift_d    = fifo_data;
                baud_clear = 1'b1;
                state_d    = START;
            end
            START: begin
                tx = START_BIT;
                if (tick) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                tx = STOP_BIT;
                if (tick) begin
                    frame_done = 1'b1;
                    state_d    = (en && !empty) ? POP : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed plus randomized checks of fifo_uart_tx against a frame-level serial model.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int CPB2 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       en2 = 1'b0;
    logic       empty, empty2;
    logic [7:0] fifo_data  = '0;
    logic [7:0] fifo_data2 = '0;
    logic       rd, tx, busy, frame_done;
    logic       rd2, tx2, busy2, frame_done2;

    int vectors = 0;
    int errors  = 0;

    // Byte FIFO models with registered data_out (one cycle after rd).
    logic [7:0] mem  [64];
    logic [7:0] mem2 [64];
    logic [5:0] wr_ptr = '0, rd_ptr = '0;
    logic [5:0] wr_ptr2 = '0, rd_ptr2 = '0;
    int rd_cnt = 0, underflow = 0;
    int rd_cnt2 = 0, underflow2 = 0;
    logic [7:0] burst_q[$];

    assign empty  = (wr_ptr == rd_ptr);
    assign empty2 = (wr_ptr2 == rd_ptr2);

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .fifo_data(fifo_data),
        .rd(rd), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(CPB2)) dut2 (
        .clk(clk), .rst(rst), .en(en2), .empty(empty2), .fifo_data(fifo_data2),
        .rd(rd2), .tx(tx2), .busy(busy2), .frame_done(frame_done2)
    );

    always @(posedge clk) begin
        if (rd) begin
            rd_cnt <= rd_cnt + 1;
            if (wr_ptr == rd_ptr) underflow <= underflow + 1;
            else begin
                fifo_data <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 6'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd2) begin
            rd_cnt2 <= rd_cnt2 + 1;
            if (wr_ptr2 == rd_ptr2) underflow2 <= underflow2 + 1;
            else begin
                fifo_data2 <= mem2[rd_ptr2];
                rd_ptr2    <= rd_ptr2 + 6'd1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    task automatic chk_bit(input logic obs, input logic exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input int obs, input int exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr      = wr_ptr + 6'd1;
    endtask

    // Called at the negedge of the first start-bit cycle; returns at the last STOP cycle.
    task automatic expect_frame(input logic [7:0] b, input int drop_at, input string tag);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < CPB; c++) begin
                int   k;
                logic eb;
                k = i * CPB + c;
                if (i == 0) eb = 1'b0;
                else if (i == 9) eb = 1'b1;
                else eb = ((int'(b) >> (i - 1)) & 1) == 1;
                chk_bit(tx, eb, {tag, "_tx"});
                chk_bit(frame_done, k == 10 * CPB - 1, {tag, "_fd"});
                chk_bit(rd, 1'b0, {tag, "_rd"});
                if (k == drop_at) en = 1'b0;
                if (k != 10 * CPB - 1) @(negedge clk);
            end
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk_bit(tx, 1'b1, {tag, "_tx"});
            chk_bit(rd, 1'b0, {tag, "_rd"});
            chk_bit(busy, 1'b0, {tag, "_busy"});
        end
    endtask

    task automatic run_burst(input string tag);
        int start_cnt;
        start_cnt = rd_cnt;
        en = 1'b0;
        foreach (burst_q[j]) push(burst_q[j]);
        en = 1'b1;
        @(negedge clk);
        chk_bit(rd, 1'b1, {tag, "_pop"});
        @(negedge clk);
        chk_bit(rd, 1'b0, {tag, "_load_rd"});
        chk_bit(tx, 1'b1, {tag, "_load_tx"});
        @(negedge clk);
        for (int j = 0; j < burst_q.size(); j++) begin
            expect_frame(burst_q[j], -1, tag);
            if (j < burst_q.size() - 1) begin
                @(negedge clk);
                chk_bit(rd, 1'b1, {tag, "_gap1_rd"});
                chk_bit(tx, 1'b1, {tag, "_gap1_tx"});
                @(negedge clk);
                chk_bit(rd, 1'b0, {tag, "_gap2_rd"});
                chk_bit(tx, 1'b1, {tag, "_gap2_tx"});
                @(negedge clk);
            end
        end
        idle_check(5, {tag, "_after"});
        chk_int(rd_cnt - start_cnt, burst_q.size(), {tag, "_rd_pulses"});
        chk_bit(empty, 1'b1, {tag, "_empty"});
    endtask

    initial begin
        int start_cnt;
        int lows;

        // Reset state
        repeat (3) @(negedge clk);
        chk_bit(tx, 1'b1, "rst_tx");
        chk_bit(rd, 1'b0, "rst_rd");
        chk_bit(busy, 1'b0, "rst_busy");
        chk_bit(frame_done, 1'b0, "rst_fd");
        chk_bit(tx2, 1'b1, "rst_tx2");
        rst = 1'b1;

        // Enabled but empty: nothing happens
        en = 1'b1;
        idle_check(100, "empty_idle");

        // Single byte, latency and frame shape
        start_cnt = rd_cnt;
        push(8'hA5);
        @(negedge clk);
        chk_bit(rd, 1'b1, "a5_pop_rd");
        chk_bit(tx, 1'b1, "a5_pop_tx");
        chk_bit(busy, 1'b1, "a5_pop_busy");
        @(negedge clk);
        chk_bit(rd, 1'b0, "a5_load_rd");
        chk_bit(tx, 1'b1, "a5_load_tx");
        @(negedge clk);
        expect_frame(8'hA5, -1, "a5");
        @(negedge clk);
        chk_bit(busy, 1'b0, "a5_done_busy");
        chk_bit(tx, 1'b1, "a5_done_tx");
        chk_int(rd_cnt - start_cnt, 1, "a5_rd_pulses");

        // Three preloaded bytes back-to-back
        burst_q = '{8'h01, 8'hFF, 8'h80};
        run_burst("b3");

        // en dropped mid-DATA: frame finishes, queued byte waits
        en = 1'b0;
        push(8'h3C);
        push(8'h55);
        en = 1'b1;
        @(negedge clk);
        chk_bit(rd, 1'b1, "drop_pop");
        @(negedge clk);
        @(negedge clk);
        expect_frame(8'h3C, 12, "drop3c");
        idle_check(20, "drop_idle");
        chk_bit(empty, 1'b0, "drop_still_queued");
        en = 1'b1;
        @(negedge clk);
        chk_bit(rd, 1'b1, "resume_pop");
        @(negedge clk);
        @(negedge clk);
        expect_frame(8'h55, -1, "resume55");
        @(negedge clk);
        chk_bit(busy, 1'b0, "resume_done_busy");

        // Randomized burst
        burst_q.delete();
        repeat (6) burst_q.push_back(8'($urandom));
        run_burst("rnd");

        // Asynchronous reset in the middle of DATA
        push(8'h96);
        @(negedge clk);
        chk_bit(rd, 1'b1, "arst_pop");
        @(negedge clk);
        @(negedge clk);
        repeat (5) @(negedge clk);
        chk_bit(tx, 1'b0, "arst_pre_tx");
        #3 rst = 1'b0;
        #1;
        chk_bit(tx, 1'b1, "arst_tx");
        chk_bit(rd, 1'b0, "arst_rd");
        chk_bit(busy, 1'b0, "arst_busy");
        @(negedge clk);
        push(8'h42);
        chk_bit(tx, 1'b1, "arst_hold_tx");
        chk_bit(rd, 1'b0, "arst_hold_rd");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_bit(rd, 1'b1, "arst_repop");
        @(negedge clk);
        chk_bit(rd, 1'b0, "arst_reload");
        @(negedge clk);
        expect_frame(8'h42, -1, "arst42");
        @(negedge clk);
        chk_bit(busy, 1'b0, "arst_done_busy");

        // CLKS_PER_BIT=2, byte 0x00: 18 low cycles then 2 stop cycles
        mem2[wr_ptr2] = 8'h00;
        wr_ptr2 = wr_ptr2 + 6'd1;
        en2 = 1'b1;
        @(negedge clk);
        chk_bit(rd2, 1'b1, "c2_pop");
        @(negedge clk);
        chk_bit(rd2, 1'b0, "c2_load_rd");
        chk_bit(tx2, 1'b1, "c2_load_tx");
        @(negedge clk);
        lows = 0;
        while (tx2 === 1'b0 && lows < 40) begin
            lows++;
            @(negedge clk);
        end
        chk_int(lows, 18, "c2_low_cycles");
        chk_bit(tx2, 1'b1, "c2_stop0_tx");
        chk_bit(frame_done2, 1'b0, "c2_stop0_fd");
        @(negedge clk);
        chk_bit(tx2, 1'b1, "c2_stop1_tx");
        chk_bit(frame_done2, 1'b1, "c2_stop1_fd");
        en2 = 1'b0;
        @(negedge clk);
        chk_bit(busy2, 1'b0, "c2_done_busy");
        chk_int(rd_cnt2, 1, "c2_rd_pulses");

        chk_int(underflow, 0, "rd_while_empty");
        chk_int(underflow2, 0, "rd2_while_empty");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain-side consumer for the team's 8-entry synchronous byte FIFO.
- Pops one byte at a time over the FIFO's rd/empty/data_out interface, where data_out is registered and valid one cycle after rd.
- Transmits each byte as an 8N1 asynchronous serial frame: start bit 0, 8 data bits LSB-first, stop bit 1.
- Sits between the FIFO and the chip-level serial pin.

Parameters:
- DATA_W, 8, data bits per frame; must match the FIFO width.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 and above.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion (0) resets immediately; release is synchronous to clk.
- en  input  1  transmit enable; sampled only in IDLE and on the last STOP cycle.
- empty  input  1  FIFO empty flag.
- fifo_data  input  DATA_W  FIFO data_out; valid the cycle after rd is high.
- rd  output  1  FIFO read strobe, exactly one cycle wide per byte.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state is not IDLE.
- frame_done  output  1  one-cycle pulse on the last cycle of STOP.

Behaviour:
- Reset values: rd=0, tx=1, busy=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- All outputs are registered or decoded from state; no combinational path from input to output.
- States: IDLE, POP, LOAD, START, DATA, STOP.
- IDLE: tx=1. If en=1 and empty=0 at an edge, go to POP; otherwise stay.
- POP: rd=1 for exactly one cycle. The FIFO updates data_out and decrements its count at the edge ending POP. Go to LOAD.
- LOAD: rd=0. Capture fifo_data into the shift register at the edge ending LOAD. Clear the baud counter. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit counter=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit.
  - At each bit end: shift right and increment the bit counter.
  - After bit DATA_W-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the last cycle. At the end of STOP:
  - if en=1 and empty=0, go to POP (back-to-back);
  - otherwise go to IDLE.
- Latency: empty=0 and en=1 sampled at edge N gives rd high in cycle N..N+1. tx falls at edge N+2.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles from tx fall to the end of STOP.
- Back-to-back gap: exactly 2 cycles of tx=1 (POP, LOAD) between consecutive frames.
- Counter widths:
  - baud counter: $clog2(CLKS_PER_BIT) bits; wraps to 0 at CLKS_PER_BIT-1.
  - bit counter: $clog2(DATA_W) bits.
- en deasserted mid-frame: the current frame completes unchanged, and no further pop is issued.
- empty is ignored outside IDLE and the STOP decision cycle. rd is never issued while empty=1 is sampled.
- Reset mid-frame: tx goes to 1 asynchronously, rd=0, state=IDLE. The partial frame is abandoned and the byte is lost.
- A FIFO that went empty during the frame leaves the block in IDLE with tx=1 and busy=0.

Decomposition:
- Shared package fifo_uart_pkg holds:
  - state enum tx_state_t {IDLE, POP, LOAD, START, DATA, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One natural sub-module, baud_tick:
  - parameterised by CLKS_PER_BIT;
  - inputs: clk, rst, clear;
  - output: tick, high on the last cycle of each bit period.
- The FSM, shift register and bit counter stay in fifo_uart_tx.

Test Plan (all with CLKS_PER_BIT=4, DATA_W=8, and the FIFO model providing 1-cycle data_out latency):
- Reset then idle, empty=1, en=1 for 100 cycles -> tx=1, rd=0, busy=0 throughout.
- Single byte 0xA5, empty falls at edge N -> rd=1 only in cycle N+1. tx from edge N+2 carries the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles (40 cycles total). frame_done pulses once, then busy=0.
- Three bytes 0x01, 0xFF, 0x80 preloaded -> three frames, each with the correct LSB-first bits. Exactly 2 idle-high cycles between frames. Exactly 3 rd pulses, and empty=1 after the third pop.
- en dropped during DATA of byte 0x3C with 0x55 still queued -> the 0x3C frame completes. No further rd, tx stays 1. Re-asserting en sends the 0x55 frame.
- rst asserted (0) asynchronously mid-DATA -> tx=1 and rd=0 within the same cycle, without waiting for a clk edge. After release with empty=0, a fresh POP and full frame follow.
- Edge case CLKS_PER_BIT=2, byte 0x00 -> start bit plus 8 zero bits = 18 low cycles, then 2 high stop cycles. Frame is 20 cycles.
